// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter: FSM states,
// header field layout and buffer sizing.
package router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_PARITY  = 2'd3
    } tx_state_e;

    localparam logic [1:0] ADDR_INVALID = 2'd3;
    localparam logic [5:0] MAX_LEN      = 6'd63;

    // One spare slot above the longest payload keeps a full packet plus a byte buffered.
    localparam int BUF_DEPTH = int'(MAX_LEN) + 1;
    localparam int BUF_AW    = 6;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_LEN_LSB  = 2;

    function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] addr);
        logic [7:0] hdr;
        hdr = 8'h00;
        hdr[HDR_ADDR_LSB +: 2] = addr;
        hdr[HDR_LEN_LSB +: 6]  = len;
        return hdr;
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Circular payload buffer with occupancy count, overflow pulse and a
// combinational head read for the transmitter.
module router_tx_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_i,
    input  logic [7:0]    wr_data_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic [AW:0]   count_o,
    output logic          ovf_o
);

    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic          full;
    logic          wr_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    // A pop in the same cycle frees the slot, so a write at full still lands.
    assign wr_ok = wr_i && (!full || pop_i);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({wr_ok, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            ovf_q <= wr_i && !wr_ok;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port writer: buffers host payload, then sends header,
// payload and XOR parity under the router's pkt_valid/busy byte protocol.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH,
    parameter int AW    = BUF_AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          pl_wr,
    input  logic [7:0]    pl_data,
    input  logic          start,
    input  logic [1:0]    dest_addr,
    input  logic [5:0]    pay_len,
    input  logic          busy,
    output logic [7:0]    data_out,
    output logic          pkt_valid,
    output logic          tx_ready,
    output logic          done,
    output logic          err,
    output logic          ovf,
    output logic [AW:0]   buf_count,
    output logic [1:0]    dbg_state
);

    // Handshake: in HEADER/PAYLOAD/PARITY the byte on data_out is consumed
    // on every rising edge where busy=0; with busy=1 everything holds.

    tx_state_e   state_q;
    logic [1:0]  addr_q;
    logic [5:0]  len_q;
    logic [5:0]  cnt_q;
    logic [7:0]  parity_q;
    logic        done_q;
    logic        err_q;
    logic [7:0]  head;
    logic        pop;
    logic        start_bad;

    assign pop       = (state_q == ST_PAYLOAD) && !busy;
    assign start_bad = (dest_addr == ADDR_INVALID) || (pay_len == 6'd0) ||
                       ({1'b0, pay_len} > buf_count);

    router_tx_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clock     (clock),
        .reset     (reset),
        .wr_i      (pl_wr),
        .wr_data_i (pl_data),
        .pop_i     (pop),
        .head_o    (head),
        .count_o   (buf_count),
        .ovf_o     (ovf)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= 2'd0;
            len_q    <= 6'd0;
            cnt_q    <= 6'd0;
            parity_q <= 8'h00;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (start_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q  <= dest_addr;
                            len_q   <= pay_len;
                            state_q <= ST_HEADER;
                        end
                    end
                end
                ST_HEADER: begin
                    if (!busy) begin
                        parity_q <= make_header(len_q, addr_q);
                        cnt_q    <= 6'd0;
                        state_q  <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (!busy) begin
                        parity_q <= parity_q ^ head;
                        cnt_q    <= cnt_q + 6'd1;
                        // len=63 finishes at cnt=62, so the 6-bit counter never wraps.
                        if (cnt_q == len_q - 6'd1) state_q <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (!busy) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        data_out = 8'h00;
        unique case (state_q)
            ST_HEADER:  data_out = make_header(len_q, addr_q);
            ST_PAYLOAD: data_out = head;
            ST_PARITY:  data_out = parity_q;
            default:    data_out = 8'h00;
        endcase
    end

    assign pkt_valid = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD);
    assign tx_ready  = (state_q == ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: a queue-based packet model predicts
// every transmitted byte and the per-cycle flags and buffer count.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pl_wr = 1'b0;
  logic [7:0] pl_data = 8'h00;
  logic       start = 1'b0;
  logic [1:0] dest_addr = 2'd0;
  logic [5:0] pay_len = 6'd0;
  logic       busy = 1'b0;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_ready;
  logic       done;
  logic       err;
  logic       ovf;
  logic [6:0] buf_count;
  logic [1:0] dbg_state;

  router_pkt_tx dut (
    .clock     (clock),
    .reset     (reset),
    .pl_wr     (pl_wr),
    .pl_data   (pl_data),
    .start     (start),
    .dest_addr (dest_addr),
    .pay_len   (pay_len),
    .busy      (busy),
    .data_out  (data_out),
    .pkt_valid (pkt_valid),
    .tx_ready  (tx_ready),
    .done      (done),
    .err       (err),
    .ovf       (ovf),
    .buf_count (buf_count),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // {pkt_valid, byte} for every byte the router should consume, in order
  logic [8:0] exp_q[$];
  // bytes the host has successfully stored and not yet sent
  logic [7:0] model_q[$];
  int m_left = 0;
  int m_sent = 0;
  int m_len  = 0;
  bit exp_done = 0;
  bit exp_err  = 0;
  bit exp_ovf  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock: drive inputs, advance the reference model, then check flags.
  task automatic cyc(input bit wr, input logic [7:0] d, input bit st,
                     input logic [1:0] a, input logic [5:0] l, input bit bsy);
    bit consume;
    bit pop;
    bit acc;
    logic [7:0] hdr;
    logic [7:0] par;
    pl_wr = wr; pl_data = d; start = st; dest_addr = a; pay_len = l; busy = bsy;
    consume = (m_left > 0) && !bsy;
    pop = consume && (m_sent >= 1) && (m_sent <= m_len);
    acc = wr && ((model_q.size() < 64) || pop);
    exp_ovf = wr && !acc;
    exp_err = 0;
    exp_done = 0;
    if (m_left == 0 && st) begin
      if (a == 2'd3 || l == 6'd0 || int'(l) > model_q.size()) begin
        exp_err = 1;
      end else begin
        hdr = {l, a};
        par = hdr;
        exp_q.push_back({1'b1, hdr});
        for (int i = 0; i < int'(l); i++) begin
          par = par ^ model_q[i];
          exp_q.push_back({1'b1, model_q[i]});
        end
        exp_q.push_back({1'b0, par});
        m_left = int'(l) + 2;
        m_sent = 0;
        m_len = int'(l);
      end
    end else if (consume) begin
      m_sent++;
      m_left--;
      if (m_left == 0) exp_done = 1;
    end
    if (pop) void'(model_q.pop_front());
    if (acc) model_q.push_back(d);
    @(posedge clock);
    #1;
    check("done", done, exp_done);
    check("err", err, exp_err);
    check("ovf", ovf, exp_ovf);
    check("buf_count", buf_count, model_q.size());
    check("tx_ready", tx_ready, m_left == 0);
    if (m_left == 0) begin
      check("idle_pkt_valid", pkt_valid, 0);
      check("idle_data_out", data_out, 0);
    end
  endtask

  task automatic idle_until_done();
    int guard;
    guard = 0;
    while (m_left > 0 && guard < 300) begin
      cyc(0, 8'h00, 0, 2'd0, 6'd0, 0);
      guard++;
    end
    if (m_left > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL packet_timeout: %0d bytes still pending", m_left);
    end
  endtask

  task automatic send(input logic [1:0] a, input logic [5:0] l);
    cyc(0, 8'h00, 1, a, l, 0);
    idle_until_done();
  endtask

  task automatic drain();
    int n;
    while (model_q.size() > 0) begin
      n = (model_q.size() > 63) ? 63 : model_q.size();
      send(2'($urandom_range(0, 2)), 6'(n));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pl_wr = 0; start = 0; busy = 0;
    exp_q.delete();
    model_q.delete();
    m_left = 0; m_sent = 0; m_len = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_buf_count", buf_count, 0);
    check("rst_data_out", data_out, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ovf", ovf, 0);
  endtask

  // Monitor: whenever a byte will be consumed at the next edge, pop and compare.
  always @(negedge clock) begin
    logic [8:0] e;
    if (!reset && !tx_ready && !busy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tx_unexpected: got %0h with nothing expected", {pkt_valid, data_out});
      end else begin
        e = exp_q.pop_front();
        check("tx_byte", {pkt_valid, data_out}, e);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // basic packet A1,B2,C3 to port 1
    cyc(1, 8'hA1, 0, 0, 0, 0);
    cyc(1, 8'hB2, 0, 0, 0, 0);
    cyc(1, 8'hC3, 0, 0, 0, 0);
    send(2'd1, 6'd3);

    // same packet, stalled twice while B2 is presented
    cyc(1, 8'hA1, 0, 0, 0, 0);
    cyc(1, 8'hB2, 0, 0, 0, 0);
    cyc(1, 8'hC3, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 2'd1, 6'd3, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 0, 1);
    idle_until_done();

    // rejected starts
    cyc(1, 8'h11, 0, 0, 0, 0);
    cyc(1, 8'h22, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 2'd3, 6'd1, 0);
    cyc(0, 8'h00, 1, 2'd0, 6'd0, 0);
    cyc(0, 8'h00, 1, 2'd2, 6'd5, 0);
    send(2'd2, 6'd2);

    // fill, overflow, then max-length packet with writes every cycle
    for (int i = 0; i < 65; i++) cyc(1, 8'($urandom), 0, 0, 0, 0);
    cyc(1, 8'($urandom), 1, 2'd0, 6'd63, 0);
    for (int i = 0; i < 66; i++) cyc(1, 8'($urandom), 0, 0, 0, 0);
    idle_until_done();
    drain();

    // reset in the middle of a payload
    for (int i = 0; i < 5; i++) cyc(1, 8'($urandom), 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 2'd0, 6'd5, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    do_reset();
    cyc(1, 8'h55, 0, 0, 0, 0);
    send(2'd2, 6'd1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(bit'($urandom_range(0, 1)), 8'($urandom),
          $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
          6'($urandom_range(0, 24)), $urandom_range(0, 3) == 0);
    end
    idle_until_done();
    drain();
    repeat (3) cyc(0, 8'h00, 0, 0, 0, 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
